// File: rtl/decode_writeback.sv
// decode_writeback: operand/destination decode with a 15-entry 64-bit register file and write-back
module decode_writeback #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RRSP  = 4'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        Cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  input  logic [3:0]  dbg_idx,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] dbg_val
);
  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];
  // Register selectors from icode; unlisted codes select no register
  always_comb begin
    srcA = (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? rA :
           (icode inside {4'h9, 4'hB}) ? RRSP : RNONE;
    srcB = (icode inside {4'h4, 4'h5, 4'h6}) ? rB :
           (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RRSP : RNONE;
    dstE = (icode inside {4'h3, 4'h6}) ? rB :
           (icode == 4'h2) ? (Cnd ? rB : RNONE) :
           (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RRSP : RNONE;
    dstM = (icode inside {4'h5, 4'hB}) ? rA : RNONE;
  end
  assign valA    = (srcA == RNONE) ? 64'd0 : regs_q[srcA];
  assign valB    = (srcB == RNONE) ? 64'd0 : regs_q[srcB];
  assign dbg_val = (dbg_idx == RNONE) ? 64'd0 : regs_q[dbg_idx];
  // Next register contents: M port checked first so it wins when both ports hit one register
  always_comb begin
    for (int i = 0; i < 15; i++)
      regs_d[i] = (wb_en && dstM == 4'(i)) ? valM :
                  (wb_en && dstE == 4'(i)) ? valE : regs_q[i];
  end
  // Register file state; reset clears all entries immediately and blocks writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      for (int i = 0; i < 15; i++) regs_q[i] <= 64'd0;
    else
      for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
  end
endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: directed self-checking bench for decode_writeback
module tb_decode_writeback;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  icode = 4'h1, rA = 4'hF, rB = 4'hF, dbg_idx = 4'h0;
  logic        Cnd = 1'b0, wb_en = 1'b0;
  logic [63:0] valE = 64'd0, valM = 64'd0;
  logic [63:0] valA, valB, dbg_val;
  logic [3:0]  srcA, srcB, dstE, dstM;
  int n_cmp = 0;
  int n_err = 0;

  decode_writeback dut (
    .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .Cnd(Cnd),
    .valE(valE), .valM(valM), .wb_en(wb_en), .dbg_idx(dbg_idx),
    .valA(valA), .valB(valB), .srcA(srcA), .srcB(srcB),
    .dstE(dstE), .dstM(dstM), .dbg_val(dbg_val)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m, input logic en);
    icode = ic; rA = a; rB = b; Cnd = c; valE = e; valM = m; wb_en = en;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    drive(4'h0, 4'h2, 4'h3, 1'b0, 64'd0, 64'd0, 1'b0);
    n_cmp++; if (valA !== 64'd0) begin n_err++; $display("FAIL reset_valA: got %0h want 0", valA); end
    n_cmp++; if (valB !== 64'd0) begin n_err++; $display("FAIL reset_valB: got %0h want 0", valB); end
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'hFFFF) begin n_err++; $display("FAIL reset_sel: got %0h want ffff", {srcA, srcB, dstE, dstM}); end
    for (int i = 0; i < 15; i++) begin
      dbg_idx = 4'(i); #1;
      n_cmp++; if (dbg_val !== 64'd0) begin n_err++; $display("FAIL reset_reg%0d: got %0h want 0", i, dbg_val); end
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_irmovq();
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'd100, 64'd0, 1'b1);
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'hFF2F) begin n_err++; $display("FAIL irmov_sel: got %0h want ff2f", {srcA, srcB, dstE, dstM}); end
    tick();
    dbg_idx = 4'h2; #1;
    n_cmp++; if (dbg_val !== 64'd100) begin n_err++; $display("FAIL irmov_r2: got %0d want 100", dbg_val); end
    drive(4'h2, 4'h2, 4'h3, 1'b1, 64'd100, 64'd0, 1'b1);
    dbg_idx = 4'h3; #1;
    n_cmp++; if (valA !== 64'd100) begin n_err++; $display("FAIL rrmov_valA: got %0d want 100", valA); end
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'h2F3F) begin n_err++; $display("FAIL rrmov_sel: got %0h want 2f3f", {srcA, srcB, dstE, dstM}); end
    n_cmp++; if (dbg_val !== 64'd0) begin n_err++; $display("FAIL rrmov_nobypass: got %0d want 0", dbg_val); end
    tick();
    n_cmp++; if (dbg_val !== 64'd100) begin n_err++; $display("FAIL rrmov_r3: got %0d want 100", dbg_val); end
  endtask

  task automatic test_cmov_not_taken();
    drive(4'h2, 4'h2, 4'h5, 1'b0, 64'd7, 64'd0, 1'b1);
    dbg_idx = 4'h5; #1;
    n_cmp++; if (dstE !== 4'hF) begin n_err++; $display("FAIL cmov_dstE: got %0h want f", dstE); end
    tick();
    n_cmp++; if (dbg_val !== 64'd0) begin n_err++; $display("FAIL cmov_r5: got %0d want 0", dbg_val); end
  endtask

  task automatic test_pushq();
    drive(4'h3, 4'hF, 4'h4, 1'b0, 64'd256, 64'd0, 1'b1);
    tick();
    drive(4'hA, 4'h3, 4'hF, 1'b0, 64'd248, 64'd0, 1'b1);
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'h344F) begin n_err++; $display("FAIL push_sel: got %0h want 344f", {srcA, srcB, dstE, dstM}); end
    n_cmp++; if (valB !== 64'd256) begin n_err++; $display("FAIL push_valB: got %0d want 256", valB); end
    n_cmp++; if (valA !== 64'd100) begin n_err++; $display("FAIL push_valA: got %0d want 100", valA); end
    tick();
    dbg_idx = 4'h4; #1;
    n_cmp++; if (dbg_val !== 64'd248) begin n_err++; $display("FAIL push_rsp: got %0d want 248", dbg_val); end
  endtask

  task automatic test_popq_rsp();
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd264, 64'd55, 1'b1);
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'h4444) begin n_err++; $display("FAIL pop_sel: got %0h want 4444", {srcA, srcB, dstE, dstM}); end
    tick();
    dbg_idx = 4'h4; #1;
    n_cmp++; if (dbg_val !== 64'd55) begin n_err++; $display("FAIL pop_mwins: got %0d want 55", dbg_val); end
    drive(4'h3, 4'hF, 4'h4, 1'b0, 64'd999, 64'd0, 1'b0);
    n_cmp++; if (dstE !== 4'h4) begin n_err++; $display("FAIL freeze_dstE: got %0h want 4", dstE); end
    tick();
    n_cmp++; if (dbg_val !== 64'd55) begin n_err++; $display("FAIL freeze_rsp: got %0d want 55", dbg_val); end
  endtask

  task automatic test_opq_mrmovq();
    drive(4'h6, 4'h2, 4'h3, 1'b0, 64'd300, 64'd0, 1'b1);
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'h233F) begin n_err++; $display("FAIL opq_sel: got %0h want 233f", {srcA, srcB, dstE, dstM}); end
    tick();
    dbg_idx = 4'h3; #1;
    n_cmp++; if (dbg_val !== 64'd300) begin n_err++; $display("FAIL opq_r3: got %0d want 300", dbg_val); end
    dbg_idx = 4'h2; #1;
    n_cmp++; if (dbg_val !== 64'd100) begin n_err++; $display("FAIL opq_r2_held: got %0d want 100", dbg_val); end
    drive(4'h5, 4'h6, 4'h2, 1'b0, 64'd11, 64'd77, 1'b1);
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'hF2F6) begin n_err++; $display("FAIL mrmov_sel: got %0h want f2f6", {srcA, srcB, dstE, dstM}); end
    n_cmp++; if (valB !== 64'd100) begin n_err++; $display("FAIL mrmov_valB: got %0d want 100", valB); end
    tick();
    dbg_idx = 4'h6; #1;
    n_cmp++; if (dbg_val !== 64'd77) begin n_err++; $display("FAIL mrmov_r6: got %0d want 77", dbg_val); end
  endtask

  task automatic test_call_ret_rmmov();
    drive(4'h8, 4'h2, 4'h3, 1'b0, 64'd0, 64'd0, 1'b0);
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'hF44F) begin n_err++; $display("FAIL call_sel: got %0h want f44f", {srcA, srcB, dstE, dstM}); end
    drive(4'h9, 4'h2, 4'h3, 1'b0, 64'd0, 64'd0, 1'b0);
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'h444F) begin n_err++; $display("FAIL ret_sel: got %0h want 444f", {srcA, srcB, dstE, dstM}); end
    n_cmp++; if (valA !== 64'd55) begin n_err++; $display("FAIL ret_valA: got %0d want 55", valA); end
    drive(4'h4, 4'h2, 4'h6, 1'b0, 64'd0, 64'd0, 1'b0);
    n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'h26FF) begin n_err++; $display("FAIL rmmov_sel: got %0h want 26ff", {srcA, srcB, dstE, dstM}); end
    n_cmp++; if (valB !== 64'd77) begin n_err++; $display("FAIL rmmov_valB: got %0d want 77", valB); end
  endtask

  task automatic test_halt_nop();
    logic [3:0] codes [7];
    logic [63:0] exp [15];
    codes = '{4'h0, 4'h1, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
    exp = '{64'd0, 64'd0, 64'd100, 64'd300, 64'd55, 64'd0, 64'd77, 64'd0,
            64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    for (int k = 0; k < 7; k++) begin
      drive(codes[k], 4'h2, 4'h3, 1'b1, 64'hDEAD, 64'hBEEF, 1'b1);
      n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'hFFFF) begin n_err++; $display("FAIL idle_sel icode=%0h: got %0h want ffff", codes[k], {srcA, srcB, dstE, dstM}); end
      n_cmp++; if ({valA, valB} !== 128'd0) begin n_err++; $display("FAIL idle_vals icode=%0h: got %0h/%0h want 0/0", codes[k], valA, valB); end
      if (k < 2) begin
        tick(); tick(); tick();
      end
    end
    for (int i = 0; i < 15; i++) begin
      dbg_idx = 4'(i); #1;
      n_cmp++; if (dbg_val !== exp[i]) begin n_err++; $display("FAIL idle_reg%0d: got %0d want %0d", i, dbg_val, exp[i]); end
    end
    dbg_idx = 4'hF; #1;
    n_cmp++; if (dbg_val !== 64'd0) begin n_err++; $display("FAIL dbg_none: got %0h want 0", dbg_val); end
  endtask

  task automatic test_reset_mid();
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'd5, 64'd0, 1'b1);
    #2 rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      dbg_idx = 4'(i); #0.1;
      n_cmp++; if (dbg_val !== 64'd0) begin n_err++; $display("FAIL midrst_reg%0d: got %0h want 0", i, dbg_val); end
    end
    tick();
    dbg_idx = 4'h7; #1;
    n_cmp++; if (dbg_val !== 64'd0) begin n_err++; $display("FAIL midrst_blocked: got %0d want 0", dbg_val); end
    rst = 1'b0;
    #1;
    n_cmp++; if (dbg_val !== 64'd0) begin n_err++; $display("FAIL postrst_noedge: got %0d want 0", dbg_val); end
    tick();
    n_cmp++; if (dbg_val !== 64'd5) begin n_err++; $display("FAIL postrst_write: got %0d want 5", dbg_val); end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_cmov_not_taken();
    test_pushq();
    test_popq_rsp();
    test_opq_mrmovq();
    test_call_ret_rmmov();
    test_halt_nop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/decode_writeback.md
DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  rising-edge clock, the block's only clock.
- rst  in  1  asynchronous reset, active-high.
- icode  in  4  instruction code from fetch.
- rA  in  4  register specifier A from fetch; 4'hF means none.
- rB  in  4  register specifier B from fetch; 4'hF means none.
- Cnd  in  1  condition result from execute; qualifies cmovXX writes.
- valE  in  64  ALU result to write back.
- valM  in  64  memory read data to write back.
- wb_en  in  1  write-back enable; 0 freezes the register file.
- dbg_idx  in  4  debug read index.
- valA  out  64  operand A.
- valB  out  64  operand B.
- srcA  out  4  selected source A.
- srcB  out  4  selected source B.
- dstE  out  4  selected E destination.
- dstM  out  4  selected M destination.
- dbg_val  out  64  contents of register dbg_idx.

REQ-002 Parameters:
- RNONE, 4'hF, no-register code.
- RRSP, 4'h4, stack pointer index.

Function
REQ-003 The block SHALL hold 15 general registers, indices 0..14, each 64 bits wide. Index 15 is not storage.

REQ-004 srcA SHALL be selected as follows:
- rA for icode 2, 4, 6 or A.
- RRSP for icode 9 or B.
- RNONE otherwise.

REQ-005 srcB SHALL be selected as follows:
- rB for icode 4, 5 or 6.
- RRSP for icode 8, 9, A or B.
- RNONE otherwise.

REQ-006 dstE SHALL be selected as follows:
- rB for icode 3 or 6.
- rB for icode 2 when Cnd=1.
- RNONE for icode 2 when Cnd=0.
- RRSP for icode 8, 9, A or B.
- RNONE otherwise.

REQ-007 dstM SHALL be rA for icode 5 or B, and RNONE otherwise.

REQ-008 Any icode not listed above, including 0 (halt), 1 (nop), 7 (jXX) and C..F, SHALL drive all four selectors to RNONE.

REQ-009 valA, valB and dbg_val SHALL be combinational reads of the current register contents. A read of index RNONE SHALL return 64'd0.

REQ-010 Reads SHALL have no bypass: a value written at an edge becomes visible only after that edge.

REQ-011 On each rising clk edge with wb_en=1 and rst=0:
- if dstE != RNONE, register[dstE] SHALL be loaded with valE;
- if dstM != RNONE, register[dstM] SHALL be loaded with valM.

REQ-012 When dstE equals dstM and both are not RNONE, valM SHALL win.

REQ-013 When wb_en=0, no register SHALL change, while the outputs SHALL keep tracking the inputs combinationally.

REQ-014 Only the addressed registers SHALL change on a write edge; all others SHALL hold their values.

REQ-015 Write-back latency SHALL be one edge: a value written at edge N is readable on valA/valB from edge N onward.

Reset
REQ-016 While rst=1, all 15 registers SHALL be cleared to 64'd0 immediately, without waiting for a clk edge.

REQ-017 While rst=1, writes SHALL be blocked.

REQ-018 The reset values of the outputs SHALL be:
- valA = 64'd0, valB = 64'd0, dbg_val = 64'd0.
- srcA, srcB, dstE and dstM follow their combinational rules.

REQ-019 Asserting rst in the middle of operation SHALL discard any write pending on the same edge.

REQ-020 After rst deasserts, the first write SHALL occur at the next qualifying rising edge.

Verification
REQ-021 The verification bench SHALL cover the following directed scenarios:
- Reset: pulse rst mid-cycle after writes → every dbg_idx 0..14 reads 0 at once, with no clk edge needed.
- irmovq: icode=3, rB=2, valE=64'd100, edge → register 2 = 100; then icode=2, rA=2, rB=3, Cnd=1, valE=100, edge → valA=100 before the edge, register 3 = 100 after.
- cmov not taken: icode=2, rA=2, rB=5, Cnd=0, valE=7 → dstE=F, register 5 unchanged at 0.
- pushq: icode=A, rA=3 with RSP=64'd256 → srcA=3, srcB=4, valB=256, dstE=4, dstM=F; with valE=248, edge → RSP=248.
- popq %rsp: icode=B, rA=4, valE=264, valM=64'd55, edge → RSP=55 (M wins); a following edge with wb_en=0 leaves RSP at 55.
- halt/nop: icode=0 and icode=1 → all selectors F, valA=valB=0, no register changes over 3 edges.
